// File: rtl/idli_uart_rx_m.sv
// idli_uart_rx_m: 8N1 UART receiver, LSB first, sampled on the undivided core clock.
// A complete byte is held and handed to the core as two nibbles, low nibble first,
// using a valid/accept handshake. Framing errors and overruns are one-cycle pulses.
//
// Ports
//   i_uart_rx_gck    clock (undivided gck)
//   i_uart_rx_rst_n  asynchronous active-low reset
//   i_uart_rx        serial line, idle high, asynchronous to gck
//   o_uart_rx_data   current nibble of the held byte
//   o_uart_rx_vld    o_uart_rx_data valid
//   i_uart_rx_acp    consumer accepts the current nibble
//   o_uart_rx_ferr   framing error pulse (stop bit sampled low)
//   o_uart_rx_ovr    overrun pulse (byte dropped, holding register full)
module idli_uart_rx_m #(
  parameter int unsigned UART_DIV = 16
) (
  input  logic       i_uart_rx_gck,
  input  logic       i_uart_rx_rst_n,
  input  logic       i_uart_rx,
  output logic [3:0] o_uart_rx_data,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx_acp,
  output logic       o_uart_rx_ferr,
  output logic       o_uart_rx_ovr
);

  localparam int unsigned CntW = $clog2(UART_DIV);
  localparam logic [CntW-1:0] HalfM1 = CntW'(UART_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(UART_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, hist_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            full_q, full_d;
  logic            nib_hi_q, nib_hi_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic fall;
  logic accept;
  logic emptying;

  assign fall     = hist_q & ~sync2_q;
  assign accept   = i_uart_rx_acp & full_q;
  assign emptying = accept & nib_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    full_d   = full_q;
    nib_hi_d = nib_hi_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    // Consumer side of the holding register.
    if (accept) begin
      if (nib_hi_q) begin
        full_d   = 1'b0;
        nib_hi_d = 1'b0;
      end else begin
        nib_hi_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Mid start bit: a high line here was a glitch.
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = StData;
            idx_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync2_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = StIdle;
            // A high-nibble accept this cycle frees the register in time.
            if (!full_q || emptying) begin
              byte_d   = shift_q;
              full_d   = 1'b1;
              nib_hi_d = 1'b0;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Hold off start detection until the line returns high.
        if (sync2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_uart_rx_gck or negedge i_uart_rx_rst_n) begin
    if (!i_uart_rx_rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 1'b1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      full_q   <= 1'b0;
      nib_hi_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= i_uart_rx;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      full_q   <= full_d;
      nib_hi_q <= nib_hi_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_uart_rx_data = nib_hi_q ? byte_q[7:4] : byte_q[3:0];
  assign o_uart_rx_vld  = full_q;
  assign o_uart_rx_ferr = ferr_q;
  assign o_uart_rx_ovr  = ovr_q;

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Directed bench for idli_uart_rx_m: one instance at UART_DIV=8, one at UART_DIV=4.
module tb_idli_uart_rx_m;

  logic       clk;
  logic       rst_n;
  logic       rx8, rx4;
  logic       acp8, acp4;
  logic [3:0] data8, data4;
  logic       vld8, vld4;
  logic       ferr8, ferr4;
  logic       ovr8, ovr4;

  int n_chk;
  int n_fail;

  // Monitor state, written only by the monitor process.
  logic [3:0] q8[$];
  logic [3:0] q4[$];
  int ovr8_cnt, ferr8_cnt, vld8_cnt, both8_cnt;
  int ovr4_cnt, ferr4_cnt;

  idli_uart_rx_m #(.UART_DIV(8)) u_dut8 (
    .i_uart_rx_gck   (clk),
    .i_uart_rx_rst_n (rst_n),
    .i_uart_rx       (rx8),
    .o_uart_rx_data  (data8),
    .o_uart_rx_vld   (vld8),
    .i_uart_rx_acp   (acp8),
    .o_uart_rx_ferr  (ferr8),
    .o_uart_rx_ovr   (ovr8)
  );

  idli_uart_rx_m #(.UART_DIV(4)) u_dut4 (
    .i_uart_rx_gck   (clk),
    .i_uart_rx_rst_n (rst_n),
    .i_uart_rx       (rx4),
    .o_uart_rx_data  (data4),
    .o_uart_rx_vld   (vld4),
    .i_uart_rx_acp   (acp4),
    .o_uart_rx_ferr  (ferr4),
    .o_uart_rx_ovr   (ovr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ovr8_cnt = 0; ferr8_cnt = 0; vld8_cnt = 0; both8_cnt = 0;
    ovr4_cnt = 0; ferr4_cnt = 0;
  end

  always @(posedge clk) begin
    if (vld8 && acp8) q8.push_back(data8);
    if (vld4 && acp4) q4.push_back(data4);
    if (ovr8) ovr8_cnt++;
    if (ferr8) ferr8_cnt++;
    if (vld8) vld8_cnt++;
    if (ovr8 && ferr8) both8_cnt++;
    if (ovr4) ovr4_cnt++;
    if (ferr4) ferr4_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx4 = v;
    else rx8 = v;
    repeat (sel ? 4 : 8) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    drive_bit(sel, stop);
    if (sel) rx4 = 1'b1;
    else rx8 = 1'b1;
  endtask

  int b, o0, f0, v0, o40, f40;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    rx8    = 1'b1;
    rx4    = 1'b1;
    acp8   = 1'b0;
    acp4   = 1'b0;
    idle(3);
    chk("reset_vld8", 32'(vld8), 0);
    chk("reset_data8", 32'(data8), 0);
    chk("reset_ferr8", 32'(ferr8), 0);
    chk("reset_ovr8", 32'(ovr8), 0);
    chk("reset_vld4", 32'(vld4), 0);
    rst_n = 1'b1;
    idle(5);

    // 0xA5 with acp held high.
    acp8 = 1'b1;
    b = q8.size(); o0 = ovr8_cnt; f0 = ferr8_cnt;
    send_frame(1'b0, 8'hA5, 1'b1);
    idle(4);
    chk("a5_count", q8.size() - b, 2);
    chk("a5_lo", 32'(q8[b]), 'h5);
    chk("a5_hi", 32'(q8[b+1]), 'hA);
    chk("a5_vld_low", 32'(vld8), 0);
    chk("a5_flags", (ovr8_cnt - o0) + (ferr8_cnt - f0), 0);

    // 0x3C held while acp stays low.
    acp8 = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        if (!(vld8 === 1'b1 && data8 === 4'hC)) bad++;
        @(negedge clk);
      end
      chk("3c_hold_bad_cycles", bad, 0);
    end
    acp8 = 1'b1;
    idle(1);
    chk("3c_hi_data", 32'(data8), 'h3);
    chk("3c_hi_vld", 32'(vld8), 1);
    idle(1);
    chk("3c_empty", 32'(vld8), 0);
    acp8 = 1'b0;

    // 0x11 then 0x22 back-to-back without accepts: overrun on the second.
    o0 = ovr8_cnt;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    idle(4);
    chk("ovr_pulses", ovr8_cnt - o0, 1);
    chk("ovr_vld", 32'(vld8), 1);
    chk("ovr_held_lo", 32'(data8), 'h1);
    b = q8.size();
    acp8 = 1'b1;
    idle(2);
    chk("ovr_held_hi", 32'(q8[b+1]), 'h1);
    chk("ovr_drained", 32'(vld8), 0);

    // 0x7E with stop low, line held low 40 cycles.
    o0 = ovr8_cnt; f0 = ferr8_cnt; v0 = vld8_cnt; b = q8.size();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b0, (i != 0 && i != 7));
    rx8 = 1'b0;
    idle(40);
    rx8 = 1'b1;
    idle(10);
    chk("ferr_pulses", ferr8_cnt - f0, 1);
    chk("ferr_no_ovr", ovr8_cnt - o0, 0);
    chk("ferr_no_vld", vld8_cnt - v0, 0);
    send_frame(1'b0, 8'h5A, 1'b1);
    idle(4);
    chk("after_break_count", q8.size() - b, 2);
    chk("after_break_lo", 32'(q8[b]), 'hA);
    chk("after_break_hi", 32'(q8[b+1]), 'h5);

    // Two-cycle low glitch on the idle line.
    o0 = ovr8_cnt; f0 = ferr8_cnt; v0 = vld8_cnt;
    rx8 = 1'b0;
    idle(2);
    rx8 = 1'b1;
    idle(30);
    chk("glitch_no_vld", vld8_cnt - v0, 0);
    chk("glitch_no_flags", (ovr8_cnt - o0) + (ferr8_cnt - f0), 0);

    // Reset during bit 4 of 0xFF, then 0x81.
    b = q8.size(); o0 = ovr8_cnt; f0 = ferr8_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    idle(4);
    rst_n = 1'b0;
    idle(3);
    chk("midrst_vld", 32'(vld8), 0);
    rst_n = 1'b1;
    idle(60);
    send_frame(1'b0, 8'h81, 1'b1);
    idle(4);
    chk("midrst_count", q8.size() - b, 2);
    chk("midrst_lo", 32'(q8[b]), 'h1);
    chk("midrst_hi", 32'(q8[b+1]), 'h8);
    chk("midrst_flags", (ovr8_cnt - o0) + (ferr8_cnt - f0), 0);
    chk("never_both", both8_cnt, 0);

    // UART_DIV=4: 0x00 then 0xFF back-to-back, acp high.
    acp4 = 1'b1;
    b = q4.size(); o40 = ovr4_cnt; f40 = ferr4_cnt;
    send_frame(1'b1, 8'h00, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b1);
    idle(4);
    chk("div4_count", q4.size() - b, 4);
    chk("div4_0", 32'(q4[b]), 'h0);
    chk("div4_1", 32'(q4[b+1]), 'h0);
    chk("div4_2", 32'(q4[b+2]), 'hF);
    chk("div4_3", 32'(q4[b+3]), 'hF);
    chk("div4_no_ovr", ovr4_cnt - o40, 0);
    chk("div4_no_ferr", ferr4_cnt - f40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
